// File: rtl/clk_rst_gen.sv
// ============================================================================
// Module   : clk_rst_gen
// Brief    : Reset sequencer plus NUM_CH programmable clock-enable dividers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_rst_gen #(
  parameter int NUM_CH   = 2,
  parameter int DIV_W    = 16,
  parameter int RST_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic [NUM_CH-1:0]       en_i,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       clk_o,
  output logic                    resetn_o,
  output logic                    rst_done
);

  localparam int                HOLD_W    = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD);

  localparam logic [0:0] ST_HOLD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // hold_cnt stops at HOLD_LAST, so it cannot wrap.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d    = ST_RUN;
        else                         hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_HOLD;
    endcase
  end

  always_comb begin
    run      = (state_q == ST_RUN);
    resetn_o = run;
    rst_done = run;
  end

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DIV_W-1:0] div;
      logic [DIV_W-1:0] cnt_q, cnt_d;
      logic             tick_q, tick_d;
      logic             clk_q, clk_d;
      logic             active;

      assign div    = div_i[i*DIV_W +: DIV_W];
      assign active = run && en_i[i];

      // >= lets a lowered divide value end the current period on the next edge.
      always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        clk_d  = 1'b0;
        if (active) begin
          if (cnt_q >= div) begin
            tick_d = 1'b1;
            clk_d  = ~clk_q;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
            clk_d = clk_q;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q  <= '0;
          tick_q <= 1'b0;
          clk_q  <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          tick_q <= tick_d;
          clk_q  <= clk_d;
        end
      end

      assign tick_o[i] = tick_q;
      assign clk_o[i]  = clk_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clk_rst_gen.sv
// ============================================================================
// Module   : tb_clk_rst_gen
// Brief    : Directed self-checking bench for clk_rst_gen (NUM_CH=2, RST_HOLD=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_rst_gen;

  localparam int NUM_CH   = 2;
  localparam int DIV_W    = 16;
  localparam int RST_HOLD = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH*DIV_W-1:0] div_i;
  logic [NUM_CH-1:0]       en_i;
  logic [NUM_CH-1:0]       tick_o;
  logic [NUM_CH-1:0]       clk_o;
  logic                    resetn_o;
  logic                    rst_done;

  int checks = 0;
  int errors = 0;

  clk_rst_gen #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .RST_HOLD(RST_HOLD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .div_i   (div_i),
    .en_i    (en_i),
    .tick_o  (tick_o),
    .clk_o   (clk_o),
    .resetn_o(resetn_o),
    .rst_done(rst_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_div(input int d0, input int d1);
    div_i = {DIV_W'(d1), DIV_W'(d0)};
  endtask

  initial begin
    reset = 1'b1;
    en_i  = '0;
    set_div(0, 0);

    // 1: reset held 5 cycles, then 17 release edges before resetn_o rises
    for (int n = 0; n < 5; n++) step();
    check("rst_resetn", 32'(resetn_o), 0);
    check("rst_done",   32'(rst_done), 0);
    check("rst_tick",   32'(tick_o),   0);
    check("rst_clko",   32'(clk_o),    0);
    reset = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      step();
      check("seq_resetn", 32'(resetn_o), (n >= 17) ? 1 : 0);
      check("seq_done",   32'(rst_done), (n >= 17) ? 1 : 0);
    end

    // 2: ch0 D=3
    set_div(3, 0);
    en_i = 2'b01;
    for (int n = 1; n <= 24; n++) begin
      step();
      check("d3_tick0", 32'(tick_o[0]), (n % 4 == 0) ? 1 : 0);
      check("d3_clk0",  32'(clk_o[0]),  32'((n / 4) % 2));
      check("d3_tick1", 32'(tick_o[1]), 0);
    end

    // 3: ch1 D=0 alongside ch0 D=5
    set_div(5, 0);
    en_i = 2'b11;
    for (int n = 1; n <= 18; n++) begin
      step();
      check("d5_tick0", 32'(tick_o[0]), (n % 6 == 0) ? 1 : 0);
      check("d5_clk0",  32'(clk_o[0]),  32'((n / 6) % 2));
      check("d0_tick1", 32'(tick_o[1]), 1);
      check("d0_clk1",  32'(clk_o[1]),  32'(n % 2));
    end

    // 4: D=9 lowered to 2 once cnt reaches 7 (clk_o[0] starts at 1 here)
    set_div(9, 0);
    en_i = 2'b01;
    for (int n = 1; n <= 7; n++) begin
      step();
      check("d9_tick0", 32'(tick_o[0]), 0);
      check("d9_clk0",  32'(clk_o[0]),  1);
      check("d9_tick1", 32'(tick_o[1]), 0);
    end
    set_div(2, 0);
    step();
    check("lower_tick0", 32'(tick_o[0]), 1);
    check("lower_clk0",  32'(clk_o[0]),  0);
    for (int m = 1; m <= 9; m++) begin
      step();
      check("d2_tick0", 32'(tick_o[0]), (m % 3 == 0) ? 1 : 0);
      check("d2_clk0",  32'(clk_o[0]),  32'((m / 3) % 2));
    end

    // 5: one-cycle reset while both channels run
    en_i = 2'b11;
    for (int m = 1; m <= 4; m++) step();
    check("pre_tick1", 32'(tick_o[1]), 1);
    check("pre_cnt0",  32'(tick_o[0]), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_resetn", 32'(resetn_o), 0);
    check("mid_done",   32'(rst_done), 0);
    check("mid_tick",   32'(tick_o),   0);
    check("mid_clko",   32'(clk_o),    0);
    for (int n = 1; n <= 17; n++) begin
      step();
      check("reseq_resetn", 32'(resetn_o), (n >= 17) ? 1 : 0);
      check("reseq_tick",   32'(tick_o),   0);
    end
    for (int m = 1; m <= 6; m++) begin
      step();
      check("restart_tick0", 32'(tick_o[0]), (m % 3 == 0) ? 1 : 0);
      check("restart_clk0",  32'(clk_o[0]),  32'((m / 3) % 2));
      check("restart_tick1", 32'(tick_o[1]), 1);
      check("restart_clk1",  32'(clk_o[1]),  32'(m % 2));
    end

    // 6: D=7, drop enable mid-period then re-enable
    set_div(7, 0);
    en_i = 2'b01;
    for (int m = 1; m <= 11; m++) begin
      step();
      check("d7_tick0", 32'(tick_o[0]), (m == 8) ? 1 : 0);
      check("d7_clk0",  32'(clk_o[0]),  (m >= 8) ? 1 : 0);
    end
    en_i = 2'b00;
    for (int m = 1; m <= 3; m++) begin
      step();
      check("off_tick0", 32'(tick_o[0]), 0);
      check("off_clk0",  32'(clk_o[0]),  0);
    end
    en_i = 2'b01;
    for (int m = 1; m <= 8; m++) begin
      step();
      check("reen_tick0", 32'(tick_o[0]), (m == 8) ? 1 : 0);
      check("reen_clk0",  32'(clk_o[0]),  (m == 8) ? 1 : 0);
    end

    // Largest divide value: no tick during the first long stretch
    set_div(16'hFFFF, 0);
    for (int m = 1; m <= 20; m++) step();
    check("dmax_tick0", 32'(tick_o[0]), 0);
    check("dmax_clk0",  32'(clk_o[0]),  1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
